// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  // addi x0, x0, 0 -- presented on deq_inst when the queue is empty
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // Default-width entry; the top re-declares it at its own XLEN/ILEN.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Memory-side, redirect and decode-side signals of the fetch queue.
interface inst_fetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            if_request;
  logic [XLEN-1:0] if_addr;
  logic            if_stall;
  logic [ILEN-1:0] if_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [ILEN-1:0] deq_inst;
  logic [CW-1:0]   count;

  modport master (
    output if_request, if_addr, deq_valid, deq_pc, deq_inst, count,
    input  if_stall, if_inst, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  if_request, if_addr, deq_valid, deq_pc, deq_inst, count,
    output if_stall, if_inst, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Circular buffer of fetch entries; no knowledge of fetch or redirect policy.
module inst_fetch_queue_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0],
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o
);
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign do_push = push_i & (count_q < CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers and occupancy; clear wins over push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC owner and request driver feeding a small decode-side queue.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q, stale_addr_q, redir_pc;
  logic [CW-1:0]   cnt;
  entry_t          head, wdata;
  logic            req, in_flight, push, pop;

  // Request depends only on registered state, never on deq_ready. Once a
  // stalled request is up, occupancy can only fall, so it stays up.
  assign req       = ~rst & ((state_q == DRAIN) | (cnt < CW'(DEPTH)));
  assign in_flight = req & bus.if_stall;
  assign push      = (state_q == RUN) & req & ~bus.if_stall & ~bus.redirect_valid;
  assign pop       = bus.deq_valid & bus.deq_ready;
  assign redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign wdata     = '{pc: fetch_pc_q, inst: bus.if_inst};

  assign bus.if_request = req;
  assign bus.if_addr    = (state_q == DRAIN) ? stale_addr_q : fetch_pc_q;
  assign bus.deq_valid  = (cnt != '0);
  assign bus.deq_pc     = bus.deq_valid ? head.pc : '0;
  assign bus.deq_inst   = bus.deq_valid ? head.inst : ILEN'(NOP_INST);
  assign bus.count      = cnt;

  // Fetch FSM: advance PC on completion, redirect restarts, DRAIN waits out
  // the access that was in flight when the redirect arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.redirect_valid) begin
            fetch_pc_q <= redir_pc;
            if (in_flight) begin
              stale_addr_q <= fetch_pc_q;
              state_q      <= DRAIN;
            end
          end else if (push) begin
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
          end
        end
        DRAIN: begin
          if (bus.redirect_valid) fetch_pc_q <= redir_pc;
          if (!bus.if_stall)      state_q    <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  inst_fetch_queue_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(wdata),
    .pop_i  (pop),
    .clear_i(bus.redirect_valid),
    .head_o (head),
    .count_o(cnt)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed vector bench for inst_fetch_queue; second instance covers PC wrap.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_queue_if #(.XLEN(64), .ILEN(32), .DEPTH(4)) ifa ();
  inst_fetch_queue_if #(.XLEN(64), .ILEN(32), .DEPTH(4)) ifb ();

  inst_fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.master)
  );
  inst_fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4),
                     .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb.master)
  );

  // Memory model: instruction word derived from its address
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  assign ifa.if_inst = inst_of(ifa.if_addr);
  assign ifb.if_inst = inst_of(ifb.if_addr);

  typedef struct {
    logic        rst, stall, rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        req;
    logic [63:0] addr;
    logic        dv;
    logic [63:0] dpc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic s, input logic rv,
                             input logic [63:0] rpc, input logic rdy,
                             input logic req, input logic [63:0] addr,
                             input logic dv, input logic [63:0] dpc,
                             input logic [2:0] cnt);
    vec_t t;
    t.rst = r; t.stall = s; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
    t.req = req; t.addr = addr; t.dv = dv; t.dpc = dpc; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation ran past its time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.if_stall = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0; ifa.deq_ready = 1'b1;
    ifb.if_stall = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_pc = '0; ifb.deq_ready = 1'b1;

    //            rst st rv rpc        rdy | req addr       dv dpc        cnt
    // streaming, deq_pc trails if_addr by one
    tbl.push_back(v(1, 0, 0, 64'h0,    1,   0, 64'h0,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h0,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h4,     1, 64'h0,    1));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h8,     1, 64'h4,    1));
    // reset mid-stream, then fill with decode stalled
    tbl.push_back(v(1, 0, 0, 64'h0,    1,   0, 64'h0,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'h0,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'h4,     1, 64'h0,    1));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'h8,     1, 64'h0,    2));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'hC,     1, 64'h0,    3));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   0, 64'h10,    1, 64'h0,    4));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   0, 64'h10,    1, 64'h0,    4));
    // drain in order while fetch resumes at 0x10
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   0, 64'h10,    1, 64'h0,    4));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h10,    1, 64'h4,    3));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h14,    1, 64'h8,    3));
    // 3-cycle stall on 0x8
    tbl.push_back(v(1, 0, 0, 64'h0,    1,   0, 64'h0,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h0,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h4,     1, 64'h0,    1));
    tbl.push_back(v(0, 1, 0, 64'h0,    1,   1, 64'h8,     1, 64'h4,    1));
    tbl.push_back(v(0, 1, 0, 64'h0,    1,   1, 64'h8,     0, 64'h0,    0));
    tbl.push_back(v(0, 1, 0, 64'h0,    1,   1, 64'h8,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h8,     0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'hC,     1, 64'h8,    1));
    // fill up, then redirect with an idle bus
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'h10,    1, 64'h8,    2));
    tbl.push_back(v(0, 0, 0, 64'h0,    0,   1, 64'h14,    1, 64'h8,    3));
    tbl.push_back(v(0, 0, 1, 64'h1002, 1,   0, 64'h18,    1, 64'h8,    4));
    // redirect on a completing access drops that instruction
    tbl.push_back(v(0, 0, 1, 64'h2000, 1,   1, 64'h1000,  0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h2000,  0, 64'h0,    0));
    tbl.push_back(v(0, 0, 1, 64'h10,   0,   1, 64'h2004,  1, 64'h2000, 1));
    // redirect while 0x10 stalls -> DRAIN, second redirect to 0x300
    tbl.push_back(v(0, 1, 0, 64'h0,    0,   1, 64'h10,    0, 64'h0,    0));
    tbl.push_back(v(0, 1, 1, 64'h200,  0,   1, 64'h10,    0, 64'h0,    0));
    tbl.push_back(v(0, 1, 0, 64'h0,    0,   1, 64'h10,    0, 64'h0,    0));
    tbl.push_back(v(0, 1, 1, 64'h300,  0,   1, 64'h10,    0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h10,    0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h300,   0, 64'h0,    0));
    tbl.push_back(v(0, 0, 0, 64'h0,    1,   1, 64'h304,   1, 64'h300,  1));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_a              = tbl[i].rst;
      ifa.if_stall       = tbl[i].stall;
      ifa.redirect_valid = tbl[i].rv;
      ifa.redirect_pc    = tbl[i].rpc;
      ifa.deq_ready      = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d.if_request", i), 64'(ifa.if_request), 64'(tbl[i].req));
      chk($sformatf("v%0d.if_addr", i),    ifa.if_addr,         tbl[i].addr);
      chk($sformatf("v%0d.deq_valid", i),  64'(ifa.deq_valid),  64'(tbl[i].dv));
      chk($sformatf("v%0d.deq_pc", i),     ifa.deq_pc,          tbl[i].dpc);
      chk($sformatf("v%0d.deq_inst", i),   64'(ifa.deq_inst),
          64'(tbl[i].dv ? inst_of(tbl[i].dpc) : 32'h13));
      chk($sformatf("v%0d.count", i),      64'(ifa.count),      64'(tbl[i].cnt));
    end

    // PC wrap from ...FFFC to 0, then reset while three entries are held
    @(negedge clk); rst_b = 1'b0; #1;
    chk("wrap.c0.if_request", 64'(ifb.if_request), 64'd1);
    chk("wrap.c0.if_addr",    ifb.if_addr,         64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.c0.deq_valid",  64'(ifb.deq_valid),  64'd0);
    @(negedge clk); #1;
    chk("wrap.c1.if_addr",    ifb.if_addr,         64'h0);
    chk("wrap.c1.deq_pc",     ifb.deq_pc,          64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap.c1.deq_inst",   64'(ifb.deq_inst),   64'(inst_of(64'hFFFF_FFFF_FFFF_FFFC)));
    @(negedge clk); ifb.deq_ready = 1'b0; #1;
    chk("wrap.c2.if_addr",    ifb.if_addr,         64'h4);
    chk("wrap.c2.deq_pc",     ifb.deq_pc,          64'h0);
    chk("wrap.c2.count",      64'(ifb.count),      64'd1);
    @(negedge clk); #1;
    chk("wrap.c3.count",      64'(ifb.count),      64'd2);
    @(negedge clk); #1;
    chk("wrap.c4.count",      64'(ifb.count),      64'd3);
    chk("wrap.c4.if_addr",    ifb.if_addr,         64'hC);
    rst_b = 1'b1; #1;
    chk("rst.async.deq_valid",  64'(ifb.deq_valid),  64'd0);
    chk("rst.async.count",      64'(ifb.count),      64'd0);
    chk("rst.async.if_request", 64'(ifb.if_request), 64'd0);
    chk("rst.async.if_addr",    ifb.if_addr,         64'hFFFF_FFFF_FFFF_FFFC);
    chk("rst.async.deq_pc",     ifb.deq_pc,          64'h0);
    chk("rst.async.deq_inst",   64'(ifb.deq_inst),   64'h13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
